// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side (in_*)
// and downstream side (out_*) grouped so stages can be chained by interface.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // The stage itself is the slave; whoever drives the words and the
  // downstream ready is the master.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer, freeze, flush with
// selective field clearing, occupancy report and a saturating stall counter.
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] CLR_MASK = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;

  // Ready comes only from en and the skid flag, so upstream never sees a
  // combinational path from downstream ready.
  assign bus.in_ready  = en & ~skid_v;
  assign bus.out_valid = en & main_v;
  assign bus.out_data  = main_d;

  assign in_fire   = bus.in_valid & bus.in_ready;
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values of main_d/skid_d, e.g. the skid-to-main shift.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= main_d & ~CLR_MASK;
      skid_d <= skid_d & ~CLR_MASK;
    end else if (en) begin
      case ({main_v, skid_v})
        2'b00: begin
          if (in_fire) begin
            main_v <= 1'b1;
            main_d <= bus.in_data;
          end
        end
        2'b10: begin
          if (out_fire && in_fire) begin
            main_d <= bus.in_data;
          end else if (out_fire) begin
            main_v <= 1'b0;
            main_d <= main_d & ~CLR_MASK;
          end else if (in_fire) begin
            skid_v <= 1'b1;
            skid_d <= bus.in_data;
          end
        end
        2'b11: begin
          // in_ready is low here, so nothing can arrive while the skid drains.
          if (out_fire) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Counts cycles a valid word was held back by downstream; flush does not
  // stop it, and it sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (en && main_v && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic, all
// checked against a queue-based reference of the stage's observable behaviour.
module tb_pipe_stage_skid;

  localparam logic [7:0] MASK = 8'hF0;

  logic       CLK = 1'b0;
  logic       RST, en, flush, in_valid, out_ready;
  logic [7:0] in_data;

  always #5 CLK = ~CLK;

  pipe_stage_skid_if #(.DATA_W(8)) bus_a ();
  pipe_stage_skid_if #(.DATA_W(8)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  pipe_stage_skid #(.DATA_W(8), .CLR_MASK(MASK), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .bus(bus_a),
    .occupancy(occ_a), .stall_cnt(cnt_a)
  );

  pipe_stage_skid #(.DATA_W(8), .CLR_MASK(MASK), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .bus(bus_b),
    .occupancy(occ_b), .stall_cnt(cnt_b)
  );

  // Reference: the held words as an ordered queue (front = visible word), the
  // value out_data rests at when empty, and two saturating counters.
  logic [7:0] mq[$];
  logic [7:0] m_idle;
  int         m_cnt_a, m_cnt_b;
  int         checks, passed;

  function automatic logic exp_ir();
    return en && (mq.size() < 2);
  endfunction

  function automatic logic exp_ov();
    return en && (mq.size() != 0);
  endfunction

  function automatic logic [7:0] exp_od();
    return (mq.size() != 0) ? mq[0] : m_idle;
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(mq.size());
  endfunction

  task automatic model_step();
    logic [7:0] popped;
    bit         in_f, out_f;
    if (RST) begin
      mq.delete();
      m_idle  = '0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      return;
    end
    if (en && mq.size() != 0 && !out_ready) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    if (flush) begin
      m_idle = exp_od() & ~MASK;
      mq.delete();
    end else if (en) begin
      in_f  = in_valid && (mq.size() < 2);
      out_f = (mq.size() != 0) && out_ready;
      if (out_f) begin
        popped = mq.pop_front();
        if (!in_f && mq.size() == 0) m_idle = popped & ~MASK;
      end
      if (in_f) mq.push_back(in_data);
    end
  endtask

  // Apply one cycle of inputs, advance the reference at the edge, settle.
  task automatic cycle(input logic r, input logic f, input logic e,
                       input logic iv, input logic [7:0] d, input logic ordy);
    RST = r; flush = f; en = e; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 0, 8'h00, 0);
    cycle(1, 0, 1, 0, 8'h00, 0);
    RST = 0;
    #1;
    checks++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_data, occ_a, cnt_a, cnt_b}
        !== {1'b0, 1'b1, 8'h00, 2'd0, 16'd0, 2'd0})
      $display("FAIL reset_idle: ov/ir/od/occ/cnt/cntb got %b %b %h %0d %0d %0d want 0 1 00 0 0 0",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data, occ_a, cnt_a, cnt_b);
    else passed++;
  endtask

  task automatic test_streaming();
    logic [7:0] w [3];
    w = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, w[i], 1);
      checks++;
      if ({bus_a.out_valid, bus_a.out_data, bus_a.in_ready, occ_a} !== {1'b1, w[i], 1'b1, 2'd1})
        $display("FAIL stream_%0d: ov/od/ir/occ got %b %h %b %0d want 1 %h 1 1",
                 i, bus_a.out_valid, bus_a.out_data, bus_a.in_ready, occ_a, w[i]);
      else passed++;
    end
    cycle(0, 0, 1, 0, 8'h00, 1);
    checks++;
    if ({bus_a.out_valid, bus_a.out_data, occ_a} !== {1'b0, 8'h03, 2'd0})
      $display("FAIL stream_drain: ov/od/occ got %b %h %0d want 0 03 0",
               bus_a.out_valid, bus_a.out_data, occ_a);
    else passed++;
  endtask

  task automatic test_backpressure();
    cycle(0, 0, 1, 1, 8'hA1, 0);
    cycle(0, 0, 1, 1, 8'hA2, 0);
    checks++;
    if ({occ_a, bus_a.in_ready, bus_a.out_data} !== {2'd2, 1'b0, 8'hA1})
      $display("FAIL skid_full: occ/ir/od got %0d %b %h want 2 0 a1", occ_a, bus_a.in_ready, bus_a.out_data);
    else passed++;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 8'hA3, 0);
    checks++;
    if ({cnt_a, cnt_b, occ_a} !== {16'd4, 2'd3, 2'd2})
      $display("FAIL stall_hold: cnt/cntb/occ got %0d %0d %0d want 4 3 2", cnt_a, cnt_b, occ_a);
    else passed++;
    cycle(0, 0, 1, 0, 8'h00, 1);
    checks++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.in_ready, occ_a} !== {1'b1, 8'hA2, 1'b1, 2'd1})
      $display("FAIL skid_drain1: ov/od/ir/occ got %b %h %b %0d want 1 a2 1 1",
               bus_a.out_valid, bus_a.out_data, bus_a.in_ready, occ_a);
    else passed++;
    cycle(0, 0, 1, 0, 8'h00, 1);
    checks++;
    if ({bus_a.out_valid, bus_a.out_data, occ_a} !== {1'b0, 8'h02, 2'd0})
      $display("FAIL skid_drain2: ov/od/occ got %b %h %0d want 0 02 0", bus_a.out_valid, bus_a.out_data, occ_a);
    else passed++;
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, 1, 8'h5C, 0);
    cycle(0, 0, 1, 1, 8'h7E, 0);
    cycle(0, 1, 1, 1, 8'h99, 0);
    checks++;
    if ({bus_a.out_valid, occ_a, bus_a.out_data, bus_b.out_data} !== {1'b0, 2'd0, 8'h0C, 8'h0C})
      $display("FAIL flush: ov/occ/od/odb got %b %0d %h %h want 0 0 0c 0c",
               bus_a.out_valid, occ_a, bus_a.out_data, bus_b.out_data);
    else passed++;
    cycle(0, 0, 1, 0, 8'h00, 1);
    checks++;
    if ({bus_a.out_valid, bus_a.out_data} !== {1'b0, 8'h0C})
      $display("FAIL flush_after: ov/od got %b %h want 0 0c", bus_a.out_valid, bus_a.out_data);
    else passed++;
  endtask

  task automatic test_freeze();
    logic [15:0] saved;
    cycle(0, 0, 1, 1, 8'h42, 0);
    saved = cnt_a;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, i[0], 8'($urandom), ~i[0]);
      checks++;
      if ({bus_a.out_valid, bus_a.in_ready, cnt_a} !== {1'b0, 1'b0, saved})
        $display("FAIL freeze_%0d: ov/ir/cnt got %b %b %0d want 0 0 %0d",
                 i, bus_a.out_valid, bus_a.in_ready, cnt_a, saved);
      else passed++;
    end
    en = 1; in_valid = 0; out_ready = 0;
    #1;
    checks++;
    if ({bus_a.out_valid, bus_a.out_data, occ_a} !== {1'b1, 8'h42, 2'd1})
      $display("FAIL unfreeze: ov/od/occ got %b %h %0d want 1 42 1", bus_a.out_valid, bus_a.out_data, occ_a);
    else passed++;
    cycle(0, 0, 1, 0, 8'h00, 1);
  endtask

  task automatic test_saturation();
    cycle(1, 0, 1, 0, 8'h00, 0);
    cycle(0, 0, 1, 1, 8'hBD, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 8'h00, 0);
    checks++;
    if ({cnt_b, cnt_a} !== {2'd3, 16'd6})
      $display("FAIL saturate: cntb/cnt got %0d %0d want 3 6", cnt_b, cnt_a);
    else passed++;
  endtask

  task automatic test_rst_priority();
    cycle(0, 0, 1, 1, 8'hEB, 0);
    cycle(1, 1, 1, 1, 8'h99, 0);
    checks++;
    if ({cnt_a, cnt_b, bus_a.out_data, bus_b.out_data, occ_a, occ_b, bus_a.out_valid}
        !== {16'd0, 2'd0, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0})
      $display("FAIL rst_flush: cnt/cntb/od/odb/occ/occb/ov got %0d %0d %h %h %0d %0d %b want 0 0 00 00 0 0 0",
               cnt_a, cnt_b, bus_a.out_data, bus_b.out_data, occ_a, occ_b, bus_a.out_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [27:0] got_a, want_a;
    logic [13:0] got_b, want_b;
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 2) != 0));
      got_a  = {bus_a.in_ready, bus_a.out_valid, bus_a.out_data, occ_a, cnt_a};
      want_a = {exp_ir(), exp_ov(), exp_od(), exp_occ(), 16'(m_cnt_a)};
      got_b  = {bus_b.in_ready, bus_b.out_valid, bus_b.out_data, occ_b, cnt_b};
      want_b = {exp_ir(), exp_ov(), exp_od(), exp_occ(), 2'(m_cnt_b)};
      checks++;
      if (got_a !== want_a)
        $display("FAIL random_a cycle %0d: ir/ov/od/occ/cnt got %h want %h", i, got_a, want_a);
      else passed++;
      checks++;
      if (got_b !== want_b)
        $display("FAIL random_b cycle %0d: ir/ov/od/occ/cnt got %h want %h", i, got_b, want_b);
      else passed++;
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    m_idle = '0; m_cnt_a = 0; m_cnt_b = 0;
    RST = 1; flush = 0; en = 0; in_valid = 0; in_data = '0; out_ready = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_saturation();
    test_rst_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
